binary_mul_pipe: RTL



---
 rtl/binary_mul_pkg.sv | 40 ++++
 rtl/binary_mul_row.sv | 68 ++++++
 rtl/binary_mul_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/binary_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : binary_mul_pkg
// Description : Shared helpers for the pipelined array multiplier. These cover
//               the latency and width helpers, the Baugh-Wooley correction
//               constant and a full-adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
package binary_mul_pkg;

    // Pipeline latency in clock enables: one stage per multiplier bit plus the final add.
    function automatic int mul_latency(input int wb);
        return wb + 1;
    endfunction

    // Product width shared by every level of the hierarchy.
    function automatic int prod_width(input int wa, input int wb);
        return wa + wb;
    endfunction

    // Correction constant for signed mode. Inverting the negatively weighted
    // partial-product bits leaves a residue of 2^(WA-1) + 2^(WB-1) - 2^(WA+WB-1).
    // Modulo 2^(WA+WB), that residue becomes the three positive terms below.
    // For WA == WB the two low terms merge into a single bit at column WA.
    function automatic logic [63:0] bw_const(input int wa, input int wb);
        logic [63:0] k;
        k = (64'd1 << (wa - 1)) + (64'd1 << (wb - 1)) + (64'd1 << (wa + wb - 1));
        if (wa + wb < 64) begin
            k = k & ((64'd1 << (wa + wb)) - 64'd1);
        end
        return k;
    endfunction

    // Full-adder cell: returns {carry, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

endpackage
`default_nettype wire

// File: rtl/binary_mul_row.sv
`default_nettype none
// ============================================================================
// Module      : binary_mul_row
// Description : One combinational carry-save row of the array multiplier.
//               It folds a & {WA{b_bit}} (weight 2^K) into the sum/carry
//               vectors and retires product bit K.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_mul_row
    import binary_mul_pkg::*;
#(
    parameter int WA = 3,
    parameter int WB = 3,
    parameter int K  = 1
) (
    input  logic [WA-1:0]    a_i,
    input  logic             b_bit_i,
    input  logic             tc_i,
    input  logic             last_row_i,
    input  logic [WA+WB-1:0] sum_i,
    input  logic [WA+WB-1:0] carry_i,
    output logic [WA+WB-1:0] sum_o,
    output logic [WA+WB-1:0] carry_o,
    output logic             bit_o
);
    localparam int PW = prod_width(WA, WB);

    logic [WA-1:0] pp_w;

    // Partial-product row. In signed mode the cross terms carrying exactly one sign bit are inverted.
    always_comb begin
        for (int i = 0; i < WA; i++) begin
            pp_w[i] = a_i[i] & b_bit_i;
            if (tc_i && ((i == WA - 1) != last_row_i)) begin
                pp_w[i] = ~pp_w[i];
            end
        end
    end

    // 3:2 compression of columns K and up. Columns below K are already retired and pass through.
    // No carry enters column K, so its sum bit is final and can be retired here.
    always_comb begin
        logic [1:0] t;
        logic       ppb;
        int         j;
        sum_o   = sum_i;
        carry_o = carry_i;
        t       = 2'b00;
        ppb     = 1'b0;
        j       = 0;
        for (int i = K; i < PW; i++) begin
            j   = i - K;
            ppb = (j < WA) ? pp_w[j] : 1'b0;
            t   = fa(sum_i[i], carry_i[i], ppb);
            sum_o[i] = t[0];
            if (i == K) begin
                carry_o[i] = 1'b0;
            end
            if (i + 1 < PW) begin
                carry_o[i+1] = t[1];
            end
        end
        bit_o    = sum_o[K];
        sum_o[K] = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/binary_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : binary_mul_pipe
// Description : Fully pipelined WA x WB array multiplier with throughput 1 and
//               latency WB+1. The unsigned/signed mode is chosen per
//               transaction, and a global enable freezes the whole pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_mul_pipe
    import binary_mul_pkg::*;
#(
    parameter int WA = 3,
    parameter int WB = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             in_valid_i,
    input  logic [WA-1:0]    a_i,
    input  logic [WB-1:0]    b_i,
    input  logic             tc_i,
    output logic [WA+WB-1:0] p_o,
    output logic             out_valid_o
);
    localparam int                PW       = prod_width(WA, WB);
    localparam logic [PW-1:0]     BW_CONST = PW'(bw_const(WA, WB));

    // Per-stage state; operands only travel as far as the last row that needs them.
    logic [WB-1:0]   vld_q, vld_d;
    logic [WB-2:0]   tc_q, tc_d;
    logic [WA-1:0]   a_q   [WB-1];
    logic [WA-1:0]   a_d   [WB-1];
    logic [WB-2:0]   b_q   [WB-1];
    logic [WB-2:0]   b_d   [WB-1];
    logic [PW-1:0]   s_q   [WB];
    logic [PW-1:0]   s_d   [WB];
    logic [PW-1:0]   c_q   [WB];
    logic [PW-1:0]   c_d   [WB];
    logic [WB-1:0]   lo_q  [WB];
    logic [WB-1:0]   lo_d  [WB];
    logic [PW-1:0]   p_q, p_d;
    logic            out_valid_q;

    logic [PW-1:0]   row_s_w   [1:WB-1];
    logic [PW-1:0]   row_c_w   [1:WB-1];
    logic [WB-1:1]   row_bit_w;
    logic [WA-1:0]   pp0_w;

    // Rows 1..WB-1, each fed by the previous stage's registers.
    for (genvar k = 1; k < WB; k++) begin : g_row
        binary_mul_row #(
            .WA (WA),
            .WB (WB),
            .K  (k)
        ) u_row (
            .a_i        (a_q[k-1]),
            .b_bit_i    (b_q[k-1][0]),
            .tc_i       (tc_q[k-1]),
            .last_row_i (k == WB - 1),
            .sum_i      (s_q[k-1]),
            .carry_i    (c_q[k-1]),
            .sum_o      (row_s_w[k]),
            .carry_o    (row_c_w[k]),
            .bit_o      (row_bit_w[k])
        );
    end

    // Next-state for every stage: row 0 plus the correction constant, then each row's outputs.
    always_comb begin
        for (int i = 0; i < WA; i++) begin
            pp0_w[i] = a_i[i] & b_i[0];
            if (tc_i && (i == WA - 1)) begin
                pp0_w[i] = ~pp0_w[i];
            end
        end
        vld_d    = {vld_q[WB-2:0], in_valid_i};
        tc_d     = '0;
        tc_d[0]  = tc_i;
        a_d      = a_q;
        b_d      = b_q;
        a_d[0]   = a_i;
        b_d[0]   = b_i[WB-1:1];
        s_d[0]   = PW'(pp0_w);
        s_d[0][0] = 1'b0;
        c_d[0]   = tc_i ? BW_CONST : '0;
        lo_d[0]  = WB'(pp0_w[0]);
        for (int k = 1; k < WB - 1; k++) begin
            tc_d[k] = tc_q[k-1];
            a_d[k]  = a_q[k-1];
            b_d[k]  = b_q[k-1] >> 1;
        end
        for (int k = 1; k < WB; k++) begin
            s_d[k]  = row_s_w[k];
            c_d[k]  = row_c_w[k];
            lo_d[k] = lo_q[k-1] | (WB'(row_bit_w[k]) << k);
        end
        // The sum/carry vectors are zero in the retired columns, so OR-ing the low bits in is exact.
        p_d = (s_q[WB-1] + c_q[WB-1]) | PW'(lo_q[WB-1]);
    end

    // Pipeline registers: cleared asynchronously, advanced together on enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            tc_q        <= '0;
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            s_q         <= '{default: '0};
            c_q         <= '{default: '0};
            lo_q        <= '{default: '0};
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (en_i) begin
            vld_q       <= vld_d;
            tc_q        <= tc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            c_q         <= c_d;
            lo_q        <= lo_d;
            p_q         <= p_d;
            out_valid_q <= vld_q[WB-1];
        end
    end

    assign p_o         = p_q;
    assign out_valid_o = out_valid_q;

endmodule
`default_nettype wire
